biquad8_coeff_loader: RTL

- Sequences coefficient loading into the 8x pole-FIR biquad DSP chains. That chain takes 5-bit coeff address, write strobe, update strobe and 18-bit data. F chain is 8 coefficients (chain addr 0-7); G chain is 9 coefficients (chain addr 16-24).
- The host writes a shadow bank. A commit snapshots the bank and streams it into the B1 cascades in shift order, then pulses update so all B2 registers switch at once.
- Sits between the register-bus decoder and the biquad FIR instance.

---
 rtl/biquad8_coeff_loader.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/biquad8_coeff_loader.sv
`default_nettype none
// ============================================================================
//  Module   : biquad8_coeff_loader
//  Purpose  : Shadow coefficient bank plus load sequencer for the 8x pole-FIR
//             biquad. A commit snapshots the bank and streams the F and G
//             words into the B1 cascades in shift order. A single update
//             pulse then moves every B1 value into B2 at the same time.
//  Revision : 1.0  initial release
// ============================================================================
module biquad8_coeff_loader #(
    parameter int NCBITS  = 18,
    parameter int F_LEN   = 8,
    parameter int G_LEN   = 9,
    parameter int G_BASE  = 16,
    parameter int DAT_LAG = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_wr_i,
    input  logic [4:0]        cfg_adr_i,
    input  logic [NCBITS-1:0] cfg_dat_i,
    input  logic              commit_i,
    output logic              busy_o,
    output logic              pending_o,
    output logic              done_o,
    output logic              loaded_o,
    output logic              cfg_err_o,
    output logic [4:0]        coeff_adr_o,
    output logic              coeff_wr_o,
    output logic              coeff_update_o,
    output logic [NCBITS-1:0] coeff_dat_o
);

    localparam int         c_NW     = F_LEN + G_LEN;
    localparam logic [4:0] c_F_ADR  = 5'(F_LEN - 1);
    localparam logic [4:0] c_G_ADR  = 5'(G_BASE + G_LEN - 1);
    localparam logic [4:0] c_F_LAST = 5'(F_LEN - 1);
    localparam logic [4:0] c_G_LAST = 5'(G_LEN - 1);
    localparam logic [4:0] c_D_LAST = 5'(DAT_LAG - 1);
    localparam logic [4:0] c_TOP    = 5'(c_NW - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LOAD_F = 3'd1;
    localparam logic [2:0] c_LOAD_G = 3'd2;
    localparam logic [2:0] c_DRAIN  = 3'd3;
    localparam logic [2:0] c_UPDATE = 3'd4;
    localparam logic [2:0] c_DONE   = 3'd5;

    logic [2:0]        r_state;
    logic [4:0]        r_cnt;
    logic              r_pending;
    logic              r_loaded;
    logic              r_err;
    logic [4:0]        r_adr;
    logic [NCBITS-1:0] r_shadow [c_NW];
    logic [NCBITS-1:0] r_active [c_NW];
    logic [NCBITS-1:0] r_pd     [DAT_LAG];

    logic              w_map_ok;
    logic [4:0]        w_map_idx;
    logic              w_start;
    logic              w_busy;
    logic              w_wr;
    logic [4:0]        w_rd_idx;
    logic [NCBITS-1:0] w_word;

    // Translate a host address into a flat bank index (F words first, then G)
    always_comb begin
        w_map_ok  = 1'b0;
        w_map_idx = 5'd0;
        if (int'(cfg_adr_i) < F_LEN) begin
            w_map_ok  = 1'b1;
            w_map_idx = cfg_adr_i;
        end else if ((int'(cfg_adr_i) >= G_BASE) && (int'(cfg_adr_i) < G_BASE + G_LEN)) begin
            w_map_ok  = 1'b1;
            w_map_idx = 5'(int'(cfg_adr_i) - G_BASE + F_LEN);
        end
    end

    assign w_busy  = (r_state == c_LOAD_F) || (r_state == c_LOAD_G) ||
                     (r_state == c_DRAIN)  || (r_state == c_UPDATE);
    assign w_wr    = (r_state == c_LOAD_F) || (r_state == c_LOAD_G);
    // A load starts from IDLE on a commit, or from DONE on a queued or fresh commit
    assign w_start = ((r_state == c_IDLE) && commit_i) ||
                     ((r_state == c_DONE) && (r_pending || commit_i));

    // Host-side shadow bank, writable at any time
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < c_NW; k++) r_shadow[k] <= '0;
        end else if (cfg_wr_i && w_map_ok) begin
            r_shadow[w_map_idx] <= cfg_dat_i;
        end
    end

    // Sticky flag for writes that hit no coefficient
    always_ff @(posedge clk) begin
        if (rst)                        r_err <= 1'b0;
        else if (cfg_wr_i && !w_map_ok) r_err <= 1'b1;
    end

    // Snapshot at load start; a same-cycle host write is folded in
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < c_NW; k++) r_active[k] <= '0;
        end else if (w_start) begin
            for (int k = 0; k < c_NW; k++) begin
                r_active[k] <= (cfg_wr_i && w_map_ok && (w_map_idx == 5'(k))) ?
                               cfg_dat_i : r_shadow[k];
            end
        end
    end

    // Highest index goes first so it ends up in the deepest DSP of each chain
    always_comb begin
        w_rd_idx = 5'd0;
        if (r_state == c_LOAD_F)      w_rd_idx = c_F_LAST - r_cnt;
        else if (r_state == c_LOAD_G) w_rd_idx = c_TOP - r_cnt;
    end
    assign w_word = r_active[w_rd_idx];

    // Load sequencer: F words, G words, drain the data lag, update, done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= 5'd0;
            r_pending <= 1'b0;
            r_loaded  <= 1'b0;
            r_adr     <= 5'd0;
        end else begin
            if (w_busy && commit_i) r_pending <= 1'b1;
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (w_start) begin
                        r_state   <= c_LOAD_F;
                        r_cnt     <= 5'd0;
                        r_adr     <= c_F_ADR;
                        r_loaded  <= 1'b0;
                        r_pending <= 1'b0;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_LOAD_F: begin
                    if (r_cnt == c_F_LAST) begin
                        r_state <= c_LOAD_G;
                        r_cnt   <= 5'd0;
                        r_adr   <= c_G_ADR;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                c_LOAD_G: begin
                    if (r_cnt == c_G_LAST) begin
                        r_state <= c_DRAIN;
                        r_cnt   <= 5'd0;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                c_DRAIN: begin
                    if (r_cnt == c_D_LAST) begin
                        r_state <= c_UPDATE;
                        r_cnt   <= 5'd0;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                c_UPDATE: begin
                    r_state  <= c_DONE;
                    r_loaded <= 1'b1;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Data lag line; the first stage holds between loads so the output holds too
    always_ff @(posedge clk) begin
        if (rst)       r_pd[0] <= '0;
        else if (w_wr) r_pd[0] <= w_word;
    end

    for (genvar g = 1; g < DAT_LAG; g++) begin : g_dat_stage
        // Pure delay stage matching the datapath CEB1 register
        always_ff @(posedge clk) begin
            if (rst) r_pd[g] <= '0;
            else     r_pd[g] <= r_pd[g-1];
        end
    end

    assign busy_o         = w_busy;
    assign pending_o      = r_pending;
    assign done_o         = (r_state == c_DONE);
    assign loaded_o       = r_loaded;
    assign cfg_err_o      = r_err;
    assign coeff_adr_o    = r_adr;
    assign coeff_wr_o     = w_wr;
    assign coeff_update_o = (r_state == c_UPDATE);
    assign coeff_dat_o    = r_pd[DAT_LAG-1];

endmodule
`default_nettype wire
